sram_frame_reader: RTL and testbench

//  Parametrised streaming reader for frame/ROI data held in the external pixel SRAM.

---
 rtl/sram_pkg.sv | 24 ++
 rtl/sram_rd_fifo.sv | 74 +++++++
 rtl/sram_frame_reader.sv | 216 +++++++++++++++++++++
 tb/tb_sram_frame_reader.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// sram_pkg
//   Shared definitions for the SRAM frame reader: default data and address
//   widths, SRAM strobe polarity constants and the reader FSM encoding.
//   No ports; imported by sram_rd_fifo and sram_frame_reader.
package sram_pkg;

  localparam int DEF_DW = 16;
  localparam int DEF_AW = 19;

  // SRAM strobes are active high.
  localparam logic SRAM_SEL_ON  = 1'b1;
  localparam logic SRAM_SEL_OFF = 1'b0;
  localparam logic SRAM_RD_ON   = 1'b1;
  localparam logic SRAM_RD_OFF  = 1'b0;
  localparam logic SRAM_WR_OFF  = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/sram_rd_fifo.sv
// sram_rd_fifo
//   Synchronous FIFO that buffers returned SRAM words ahead of the pixel
//   stream. First-word-fall-through: head shows the oldest entry while the
//   FIFO is not empty.
// Ports
//   clk, rst    clock, synchronous active-high reset (empties the FIFO)
//   push        write push_data this cycle
//   push_data   word to store
//   pop         discard the head entry this cycle (never while empty)
//   head        oldest entry
//   empty       no entries stored
//   count       number of entries stored (0..DEPTH)
module sram_rd_fifo
  import sram_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;

  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(DEPTH));
  assign head  = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // The reader's credit scheme must never let these happen.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop));
  a_no_underflow : assert property (@(posedge clk) disable iff (rst)
    !(pop && empty));

endmodule

// File: rtl/sram_frame_reader.sv
// sram_frame_reader
//   Streams a full frame or a rectangular window out of the pixel SRAM.
//   Issues one read per cycle while credit is available, tracks the fixed
//   SRAM read latency with a valid shift register, and buffers returned
//   words in a FIFO feeding a valid/ready pixel stream.
// Ports
//   wclk, rst              clock, synchronous active-high reset (aborts a frame)
//   enable                 start request, sampled only while idle
//   base_addr, stride      frame base word address, words per line
//   x0, y0, win_w, win_h   window origin and size (latched at start)
//   selec_out_sram         SRAM chip select
//   write_out_sram         SRAM write strobe, always inactive
//   read_out_sram          SRAM read strobe, one word per cycle
//   addr_wr_out_sram       SRAM word address
//   data_wr_out_out_sram   SRAM read data, valid READ_LAT cycles after the strobe
//   pix_data, pix_valid    output pixel stream (FIFO head)
//   pix_ready              consumer accepts on pix_valid & pix_ready
//   busy                   high while a frame is being read or drained
//   frame_done             one-cycle pulse after the last pixel is accepted
// Stream handshake: a pixel transfers on any cycle where pix_valid and
// pix_ready are both high; once pix_valid rises it stays high and pix_data
// stays stable until that transfer happens.
module sram_frame_reader
  import sram_pkg::*;
#(
  parameter int DW         = DEF_DW,
  parameter int AW         = DEF_AW,
  parameter int CW         = 10,
  parameter int READ_LAT   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          wclk,
  input  logic          rst,
  input  logic          enable,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] stride,
  input  logic [CW-1:0] x0,
  input  logic [CW-1:0] y0,
  input  logic [CW-1:0] win_w,
  input  logic [CW-1:0] win_h,
  output logic          selec_out_sram,
  output logic          write_out_sram,
  output logic          read_out_sram,
  output logic [AW-1:0] addr_wr_out_sram,
  input  logic [DW-1:0] data_wr_out_out_sram,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          busy,
  output logic          frame_done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W+1)'(FIFO_DEPTH);

  rd_state_t state;
  rd_state_t next_state;

  // Latched frame configuration and walk counters
  logic [AW-1:0]       stride_q;
  logic [CW-1:0]       win_w_q;
  logic [CW-1:0]       win_h_q;
  logic [AW-1:0]       line_addr;
  logic [CW-1:0]       col;
  logic [CW-1:0]       row;
  logic [AW-1:0]       origin;

  // Latency tracking and credit
  logic [READ_LAT-1:0] lat_pipe;
  logic                ret;
  logic [CNT_W-1:0]    outstanding;
  logic [CNT_W-1:0]    fifo_count;
  logic                credit;

  logic                start;
  logic                issue;
  logic                col_last;
  logic                row_last;
  logic                last_word;

  logic [DW-1:0]       fifo_head;
  logic                fifo_empty;
  logic                pop;

  // Window origin; y0*stride is only evaluated in the idle->issue cycle.
  assign origin = base_addr + AW'(y0) * stride + AW'(x0);

  assign col_last  = (col == win_w_q - CW'(1));
  assign row_last  = (row == win_h_q - CW'(1));
  assign last_word = col_last && row_last;

  // The word emerging from the latency pipe is written into the FIFO.
  assign ret = lat_pipe[READ_LAT-1];

  // Every in-flight read already owns a FIFO slot, so a push can never
  // find the FIFO full. Pops in the same cycle are not credited back early.
  assign credit = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_LIM;

  assign pix_valid = !fifo_empty;
  assign pix_data  = pix_valid ? fifo_head : '0;
  assign pop       = pix_valid && pix_ready;

  assign write_out_sram = SRAM_WR_OFF;

  always_ff @(posedge wclk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state       = state;
    start            = 1'b0;
    issue            = 1'b0;
    busy             = 1'b0;
    read_out_sram    = SRAM_RD_OFF;
    selec_out_sram   = SRAM_SEL_OFF;
    addr_wr_out_sram = '0;
    case (state)
      S_IDLE: begin
        if (enable) begin
          start = 1'b1;
          if (win_w == '0 || win_h == '0) begin
            next_state = S_DONE;
          end else begin
            next_state = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        busy = 1'b1;
        // Address is held on stall cycles because col only moves on issue.
        addr_wr_out_sram = line_addr + AW'(col);
        if (credit) begin
          issue          = 1'b1;
          read_out_sram  = SRAM_RD_ON;
          selec_out_sram = SRAM_SEL_ON;
          if (last_word) begin
            next_state = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        // An empty FIFO here means the final pixel has been handed over.
        if (outstanding == '0 && fifo_count == '0) begin
          next_state = S_DONE;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wclk) begin
    if (rst) begin
      stride_q    <= '0;
      win_w_q     <= '0;
      win_h_q     <= '0;
      line_addr   <= '0;
      col         <= '0;
      row         <= '0;
      lat_pipe    <= '0;
      outstanding <= '0;
      frame_done  <= 1'b0;
    end else begin
      // Registered so the pulse follows the S_DONE cycle.
      frame_done <= (state == S_DONE);
      lat_pipe   <= (lat_pipe << 1) | READ_LAT'(issue);

      case ({issue, ret})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase

      if (start) begin
        stride_q  <= stride;
        win_w_q   <= win_w;
        win_h_q   <= win_h;
        line_addr <= origin;
        col       <= '0;
        row       <= '0;
      end else if (issue) begin
        if (col_last) begin
          col       <= '0;
          row       <= row + CW'(1);
          line_addr <= line_addr + stride_q;
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  sram_rd_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (wclk),
    .rst       (rst),
    .push      (ret),
    .push_data (data_wr_out_out_sram),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_sram_frame_reader.sv
// tb_sram_frame_reader
//   Directed bench for sram_frame_reader with a READ_LAT=2 SRAM model whose
//   data word is a fixed function of the address.
module tb_sram_frame_reader;

  localparam int DW = 16;
  localparam int AW = 19;
  localparam int CW = 10;

  // ---------------- clock / reset ----------------
  logic          wclk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] stride = '0;
  logic [CW-1:0] x0 = '0;
  logic [CW-1:0] y0 = '0;
  logic [CW-1:0] win_w = '0;
  logic [CW-1:0] win_h = '0;
  logic          pix_ready = 1'b1;
  logic [DW-1:0] sram_data;
  logic          selec_out_sram, write_out_sram, read_out_sram;
  logic [AW-1:0] addr_wr_out_sram;
  logic [DW-1:0] pix_data;
  logic          pix_valid, busy, frame_done;

  always #5 wclk = ~wclk;

  sram_frame_reader dut (
    .wclk                 (wclk),
    .rst                  (rst),
    .enable               (enable),
    .base_addr            (base_addr),
    .stride               (stride),
    .x0                   (x0),
    .y0                   (y0),
    .win_w                (win_w),
    .win_h                (win_h),
    .selec_out_sram       (selec_out_sram),
    .write_out_sram       (write_out_sram),
    .read_out_sram        (read_out_sram),
    .addr_wr_out_sram     (addr_wr_out_sram),
    .data_wr_out_out_sram (sram_data),
    .pix_data             (pix_data),
    .pix_valid            (pix_valid),
    .pix_ready            (pix_ready),
    .busy                 (busy),
    .frame_done           (frame_done)
  );

  function automatic logic [DW-1:0] pix_of(input logic [AW-1:0] a);
    return {a[18:16], 13'b0} ^ a[15:0] ^ 16'hA5A5;
  endfunction

  // ---------------- SRAM model, two-cycle read latency ----------------
  logic          rd_d1 = 1'b0, rd_d2 = 1'b0;
  logic [AW-1:0] ad_d1 = '0, ad_d2 = '0;
  always @(posedge wclk) begin
    rd_d1 <= read_out_sram;
    ad_d1 <= addr_wr_out_sram;
    rd_d2 <= rd_d1;
    ad_d2 <= ad_d1;
  end
  assign sram_data = rd_d2 ? pix_of(ad_d2) : 16'hDEAD;

  // ---------------- monitor / scoreboard ----------------
  int            cyc = 0;
  int            checks = 0;
  int            passed = 0;
  int            start_cyc = 0;
  logic [AW-1:0] rd_addr_q[$];
  int            rd_cyc_q[$];
  logic [DW-1:0] pix_q[$];
  logic [AW-1:0] exp_q[$];
  int            first_valid_cyc = -1;
  int            done_cnt = 0, done_cyc = -1, busy_cnt = 0, wr_hits = 0, hold_err = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  bit            pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always @(posedge wclk) cyc <= cyc + 1;

  always @(negedge wclk) begin
    if (read_out_sram === 1'b1) begin
      rd_addr_q.push_back(addr_wr_out_sram);
      rd_cyc_q.push_back(cyc);
    end
    if (pix_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (pix_valid === 1'b1 && pix_ready) pix_q.push_back(pix_data);
    if (frame_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy === 1'b1) busy_cnt++;
    if (write_out_sram !== 1'b0) wr_hits++;
    if (prev_stall && !rst && (pix_valid !== 1'b1 || pix_data !== prev_data)) hold_err++;
    prev_stall = (pix_valid === 1'b1) && !pix_ready && !rst;
    prev_data  = pix_data;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    rd_addr_q.delete();
    rd_cyc_q.delete();
    pix_q.delete();
    exp_q.delete();
    first_valid_cyc = -1;
    done_cnt = 0;
    done_cyc = -1;
    busy_cnt = 0;
    hold_err = 0;
  endtask

  task automatic start_frame(input logic [AW-1:0] b, input logic [AW-1:0] s,
                             input logic [CW-1:0] x, input logic [CW-1:0] y,
                             input logic [CW-1:0] w, input logic [CW-1:0] h);
    @(posedge wclk); #1;
    base_addr = b; stride = s; x0 = x; y0 = y; win_w = w; win_h = h;
    enable = 1'b1;
    start_cyc = cyc;
    @(posedge wclk); #1;
    enable = 1'b0;
    // Config is don't-care after the start cycle.
    base_addr = 19'h5A5A5; stride = 19'h1234; x0 = 10'd7; y0 = 10'd9;
    win_w = 10'd1; win_h = 10'd1;
  endtask

  task automatic wait_done(input int budget, input bit toggle);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(posedge wclk); #1;
      if (toggle) pix_ready = pat[k % 4];
      k++;
    end
    pix_ready = 1'b1;
    checks++;
    if (done_cnt == 0) $display("FAIL frame_done_timeout: got none within %0d cycles, want 1 pulse", budget);
    else passed++;
    repeat (4) @(posedge wclk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge wclk);
    @(negedge wclk);
    checks++;
    if ({selec_out_sram, write_out_sram, read_out_sram, busy, frame_done, pix_valid} !== 6'b0)
      $display("FAIL reset_strobes: got %b want 000000",
               {selec_out_sram, write_out_sram, read_out_sram, busy, frame_done, pix_valid});
    else passed++;
    checks++;
    if (addr_wr_out_sram !== '0) $display("FAIL reset_addr: got %h want 0", addr_wr_out_sram);
    else passed++;
    checks++;
    if (pix_data !== '0) $display("FAIL reset_pix_data: got %h want 0", pix_data);
    else passed++;
    @(posedge wclk); #1;
    rst = 1'b0;
  endtask

  task automatic test_full_frame();
    clear_logs();
    for (int i = 0; i < 8; i++) exp_q.push_back(AW'(i));
    start_frame(19'h0, 19'd4, 10'd0, 10'd0, 10'd4, 10'd2);
    wait_done(100, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= rd_addr_q.size()) $display("FAIL full_addr[%0d]: got none want %h", i, exp_q[i]);
      else if (rd_addr_q[i] !== exp_q[i]) $display("FAIL full_addr[%0d]: got %h want %h", i, rd_addr_q[i], exp_q[i]);
      else passed++;
      checks++;
      if (i >= pix_q.size()) $display("FAIL full_pix[%0d]: got none want %h", i, pix_of(exp_q[i]));
      else if (pix_q[i] !== pix_of(exp_q[i])) $display("FAIL full_pix[%0d]: got %h want %h", i, pix_q[i], pix_of(exp_q[i]));
      else passed++;
    end
    checks++;
    if (rd_addr_q.size() != 8 || pix_q.size() != 8)
      $display("FAIL full_counts: got %0d reads %0d pixels want 8 and 8", rd_addr_q.size(), pix_q.size());
    else passed++;
    checks++;
    if (rd_cyc_q.size() == 8 && (rd_cyc_q[0] != start_cyc + 1 || rd_cyc_q[7] != start_cyc + 8))
      $display("FAIL full_read_timing: got first %0d last %0d want %0d and %0d",
               rd_cyc_q[0], rd_cyc_q[7], start_cyc + 1, start_cyc + 8);
    else passed++;
    checks++;
    if (first_valid_cyc != start_cyc + 4)
      $display("FAIL full_first_valid: got cycle %0d want %0d", first_valid_cyc, start_cyc + 4);
    else passed++;
    checks++;
    if (done_cnt != 1 || busy !== 1'b0)
      $display("FAIL full_done: got done_cnt %0d busy %b want 1 and 0", done_cnt, busy);
    else passed++;
  endtask

  task automatic test_roi();
    clear_logs();
    exp_q = '{19'h382, 19'h383, 19'h384, 19'h602, 19'h603, 19'h604};
    start_frame(19'h100, 19'd640, 10'd2, 10'd1, 10'd3, 10'd2);
    wait_done(100, 1'b0);
    checks++;
    if (rd_addr_q.size() != 6 || pix_q.size() != 6)
      $display("FAIL roi_counts: got %0d reads %0d pixels want 6 and 6", rd_addr_q.size(), pix_q.size());
    else passed++;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= rd_addr_q.size() || i >= pix_q.size()) $display("FAIL roi[%0d]: got none want addr %h", i, exp_q[i]);
      else if (rd_addr_q[i] !== exp_q[i] || pix_q[i] !== pix_of(exp_q[i]))
        $display("FAIL roi[%0d]: got addr %h pix %h want addr %h pix %h",
                 i, rd_addr_q[i], pix_q[i], exp_q[i], pix_of(exp_q[i]));
      else passed++;
    end
  endtask

  task automatic test_back_pressure();
    clear_logs();
    for (int i = 0; i < 8; i++) exp_q.push_back(AW'(i));
    start_frame(19'h0, 19'd4, 10'd0, 10'd0, 10'd4, 10'd2);
    wait_done(200, 1'b1);
    checks++;
    if (pix_q.size() != 8) $display("FAIL bp_count: got %0d pixels want 8", pix_q.size());
    else passed++;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= pix_q.size()) $display("FAIL bp_pix[%0d]: got none want %h", i, pix_of(exp_q[i]));
      else if (pix_q[i] !== pix_of(exp_q[i])) $display("FAIL bp_pix[%0d]: got %h want %h", i, pix_q[i], pix_of(exp_q[i]));
      else passed++;
    end
    checks++;
    if (rd_cyc_q.size() != 8 || (rd_cyc_q[7] - rd_cyc_q[0]) <= 7)
      $display("FAIL bp_stall: got %0d reads span %0d want 8 reads span > 7",
               rd_cyc_q.size(), rd_cyc_q.size() > 0 ? rd_cyc_q[rd_cyc_q.size()-1] - rd_cyc_q[0] : 0);
    else passed++;
    checks++;
    if (hold_err != 0) $display("FAIL bp_hold: got %0d unstable stalled cycles want 0", hold_err);
    else passed++;
  endtask

  task automatic test_zero_size();
    clear_logs();
    start_frame(19'h40, 19'd4, 10'd0, 10'd0, 10'd0, 10'd2);
    repeat (6) @(posedge wclk);
    #1;
    checks++;
    if (rd_addr_q.size() != 0) $display("FAIL zero_reads: got %0d want 0", rd_addr_q.size());
    else passed++;
    checks++;
    if (done_cnt != 1 || done_cyc != start_cyc + 2)
      $display("FAIL zero_done: got %0d pulses at cycle %0d want 1 at %0d", done_cnt, done_cyc, start_cyc + 2);
    else passed++;
    checks++;
    if (busy_cnt != 0) $display("FAIL zero_busy: got %0d busy cycles want 0", busy_cnt);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    int k;
    clear_logs();
    start_frame(19'h0, 19'd4, 10'd0, 10'd0, 10'd4, 10'd2);
    k = 0;
    while (pix_q.size() < 3 && k < 50) begin
      @(posedge wclk); #1;
      k++;
    end
    checks++;
    if (pix_q.size() < 3) $display("FAIL mid_reach: got %0d pixels want 3", pix_q.size());
    else passed++;
    rst = 1'b1;
    @(posedge wclk); #1;
    rst = 1'b0;
    @(negedge wclk);
    checks++;
    if ({selec_out_sram, write_out_sram, read_out_sram, busy, frame_done, pix_valid} !== 6'b0)
      $display("FAIL mid_strobes: got %b want 000000",
               {selec_out_sram, write_out_sram, read_out_sram, busy, frame_done, pix_valid});
    else passed++;
    checks++;
    if (addr_wr_out_sram !== '0 || pix_data !== '0)
      $display("FAIL mid_buses: got addr %h pix %h want 0 and 0", addr_wr_out_sram, pix_data);
    else passed++;
    repeat (20) @(posedge wclk);
    #1;
    checks++;
    if (done_cnt != 0) $display("FAIL mid_no_done: got %0d pulses want 0", done_cnt);
    else passed++;
    clear_logs();
    for (int i = 0; i < 8; i++) exp_q.push_back(AW'(i));
    start_frame(19'h0, 19'd4, 10'd0, 10'd0, 10'd4, 10'd2);
    wait_done(100, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= rd_addr_q.size() || i >= pix_q.size()) $display("FAIL restart[%0d]: got none want addr %h", i, exp_q[i]);
      else if (rd_addr_q[i] !== exp_q[i] || pix_q[i] !== pix_of(exp_q[i]))
        $display("FAIL restart[%0d]: got addr %h pix %h want addr %h pix %h",
                 i, rd_addr_q[i], pix_q[i], exp_q[i], pix_of(exp_q[i]));
      else passed++;
    end
  endtask

  task automatic test_wrap();
    clear_logs();
    exp_q = '{19'h7FFFE, 19'h7FFFF, 19'h00000, 19'h00001};
    start_frame(19'h7FFFE, 19'd4, 10'd0, 10'd0, 10'd4, 10'd1);
    wait_done(100, 1'b0);
    checks++;
    if (rd_addr_q.size() != 4 || pix_q.size() != 4)
      $display("FAIL wrap_counts: got %0d reads %0d pixels want 4 and 4", rd_addr_q.size(), pix_q.size());
    else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= rd_addr_q.size() || i >= pix_q.size()) $display("FAIL wrap[%0d]: got none want addr %h", i, exp_q[i]);
      else if (rd_addr_q[i] !== exp_q[i] || pix_q[i] !== pix_of(exp_q[i]))
        $display("FAIL wrap[%0d]: got addr %h pix %h want addr %h pix %h",
                 i, rd_addr_q[i], pix_q[i], exp_q[i], pix_of(exp_q[i]));
      else passed++;
    end
  endtask

  task automatic test_enable_while_busy();
    clear_logs();
    for (int i = 0; i < 8; i++) exp_q.push_back(AW'(i));
    start_frame(19'h0, 19'd4, 10'd0, 10'd0, 10'd4, 10'd2);
    base_addr = 19'h200; win_w = 10'd3; win_h = 10'd3;
    enable = 1'b1;
    repeat (3) @(posedge wclk);
    #1;
    enable = 1'b0;
    wait_done(100, 1'b0);
    checks++;
    if (rd_addr_q.size() != 8 || done_cnt != 1)
      $display("FAIL busy_enable_counts: got %0d reads %0d pulses want 8 and 1", rd_addr_q.size(), done_cnt);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= rd_addr_q.size()) $display("FAIL busy_enable_addr[%0d]: got none want %h", i, exp_q[i]);
      else if (rd_addr_q[i] !== exp_q[i]) $display("FAIL busy_enable_addr[%0d]: got %h want %h", i, rd_addr_q[i], exp_q[i]);
      else passed++;
    end
    checks++;
    if (wr_hits != 0) $display("FAIL write_strobe: got %0d active cycles want 0", wr_hits);
    else passed++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_full_frame();
    test_roi();
    test_back_pressure();
    test_zero_size();
    test_reset_mid_frame();
    test_wrap();
    test_enable_while_busy();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by time 100000 want completion");
    $fatal(1);
  end

endmodule
